// File: rtl/hazard_trace_buffer.sv
// Hazard event trace buffer for the pipeline hazard detection unit.
// Captures classified hazard events (RAW/WAR/WAW) with register indices and
// a free-running timestamp into a circular buffer read over valid/ready.
// Keeps saturating per-type counters; stop-on-full or overwrite-oldest capture.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   cap_en, mode_wrap   : capture enable, 1 = overwrite oldest when full
//   clear               : flush buffer, overflow flag and counters
//   hz_valid/type/src/dst : incoming hazard event
//   out_valid/ready/data : head entry {ts, type, src, dst}
//   count, overflow     : occupancy, sticky drop/overwrite flag
//   raw/war/waw_cnt     : saturating per-type event counters
module hazard_trace_buffer #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cap_en,
  input  logic                            mode_wrap,
  input  logic                            clear,
  input  logic                            hz_valid,
  input  logic [1:0]                      hz_type,
  input  logic [REG_W-1:0]                hz_src,
  input  logic [REG_W-1:0]                hz_dst,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TS_W+2+2*REG_W-1:0]       out_data,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            overflow,
  output logic [CNT_W-1:0]                raw_cnt,
  output logic [CNT_W-1:0]                war_cnt,
  output logic [CNT_W-1:0]                waw_cnt
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned COUNT_W = $clog2(DEPTH+1);
  localparam int unsigned DATA_W  = TS_W + 2 + 2*REG_W;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [1:0]       typ;
    logic [REG_W-1:0] src;
    logic [REG_W-1:0] dst;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   raw_cnt_q, raw_cnt_d;
  logic [CNT_W-1:0]   war_cnt_q, war_cnt_d;
  logic [CNT_W-1:0]   waw_cnt_q, waw_cnt_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic               mem_we;
  entry_t             wr_entry;
  logic               qual, pop, full, push_ok;

  // Next-state: clear dominates; otherwise push/pop/overwrite bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    raw_cnt_d  = raw_cnt_q;
    war_cnt_d  = war_cnt_q;
    waw_cnt_d  = waw_cnt_q;
    ts_d       = ts_q + TS_W'(1);
    mem_we     = 1'b0;
    wr_entry   = {ts_q, hz_type, hz_src, hz_dst};

    qual    = hz_valid & cap_en & (hz_type != 2'b00);
    pop     = (count_q != COUNT_W'(0)) & out_ready;
    full    = (count_q == COUNT_W'(DEPTH));
    // A push is taken unless the buffer is full, nothing pops and we stop-on-full.
    push_ok = qual & (~full | pop | mode_wrap);

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      raw_cnt_d  = '0;
      war_cnt_d  = '0;
      waw_cnt_d  = '0;
    end else begin
      // Counters see every qualified event, including dropped ones.
      if (qual) begin
        case (hz_type)
          2'b01:   if (raw_cnt_q != '1) raw_cnt_d = raw_cnt_q + CNT_W'(1);
          2'b10:   if (war_cnt_q != '1) war_cnt_d = war_cnt_q + CNT_W'(1);
          2'b11:   if (waw_cnt_q != '1) waw_cnt_d = waw_cnt_q + CNT_W'(1);
          default: ;
        endcase
      end

      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      // Overwrite when full without a pop drags the head forward as well.
      if (pop || (qual && full && mode_wrap)) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (qual && full && !pop) overflow_d = 1'b1;

      if (push_ok && !pop && !full)  count_d = count_q + COUNT_W'(1);
      else if (pop && !push_ok)      count_d = count_q - COUNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      raw_cnt_q  <= '0;
      war_cnt_q  <= '0;
      waw_cnt_q  <= '0;
      ts_q       <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      raw_cnt_q  <= raw_cnt_d;
      war_cnt_q  <= war_cnt_d;
      waw_cnt_q  <= waw_cnt_d;
      ts_q       <= ts_d;
    end
  end

  // Trace storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head is read straight from storage; forced to zero while empty.
  assign out_valid = (count_q != COUNT_W'(0));
  assign out_data  = out_valid ? DATA_W'(mem_q[rd_ptr_q]) : DATA_W'(0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign raw_cnt   = raw_cnt_q;
  assign war_cnt   = war_cnt_q;
  assign waw_cnt   = waw_cnt_q;

endmodule

// File: doc/hazard_trace_buffer.md
Name: hazard_trace_buffer

Overview:
- Parametrised hazard event logger for the 5-stage pipeline's hazard detection unit.
- Each cycle it captures a classified hazard event: RAW, WAR or WAW, with source and destination register indices and a cycle timestamp.
- Events go into a circular trace buffer, read out over a valid/ready port by the debug/display path.
- Keeps saturating per-type hazard counters, and supports stop-on-full and overwrite-oldest capture modes.

Parameters:
REG_W, 3, register index width (8-entry register file)
DEPTH, 8, trace buffer entries; power of two, >= 2
TS_W, 8, timestamp counter width
CNT_W, 8, per-type hazard counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
cap_en  in  1  capture enable; 0 = incoming events ignored (not logged, not counted)
mode_wrap  in  1  0 = stop-on-full, 1 = overwrite oldest when full
clear  in  1  synchronous flush of buffer, overflow flag and counters
hz_valid  in  1  hazard event present this cycle
hz_type  in  2  01 RAW, 10 WAR, 11 WAW, 00 reserved (ignored)
hz_src  in  REG_W  source register index
hz_dst  in  REG_W  destination register index
out_valid  out  1  buffer non-empty
out_ready  in  1  consumer accepts head entry
out_data  out  TS_W+2+2*REG_W  head entry {ts, type, src, dst}, MSB first
count  out  $clog2(DEPTH+1)  entries held
overflow  out  1  sticky: at least one event dropped or overwritten
raw_cnt  out  CNT_W  saturating RAW event count
war_cnt  out  CNT_W  saturating WAR event count
waw_cnt  out  CNT_W  saturating WAW event count

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - Pointers, count, overflow, all counters and timestamp go to 0.
  - out_valid=0 and out_data=0.
  - Memory contents are don't-care.
  - Reset mid-readout discards all entries.
- Timestamp:
  - Free-running TS_W counter, +1 every cycle, wraps to 0.
  - Not affected by clear.
- Qualified event: hz_valid & cap_en & (hz_type != 00).
- Push:
  - A qualified event is written at wr_ptr with ts equal to the timestamp value in that same cycle.
  - It is visible at out_data from the next cycle when the buffer was empty (1-cycle latency, first-word-fall-through).
- Pop:
  - Occurs when out_valid & out_ready.
  - rd_ptr advances and out_data shows the next entry in the following cycle.
- out_valid = (count != 0).
  - out_data is registered/combinational from mem[rd_ptr].
  - out_data is held stable while out_valid & !out_ready, unless an overwrite occurs (see below).
- Full, mode_wrap=0:
  - Qualified push without a simultaneous pop is dropped; overflow <= 1.
  - Push with a simultaneous pop is accepted; count stays DEPTH.
- Full, mode_wrap=1:
  - Push overwrites the oldest entry; rd_ptr and wr_ptr both advance; count stays DEPTH; overflow <= 1.
  - If a pop coincides, the pop consumes the current head and rd_ptr advances exactly once; the push is still accepted; overflow is not set for that cycle.
- Empty: a pop request is ignored.
  - Push with out_ready=1 while empty does not pop the same cycle.
- Pointers: log2(DEPTH) bits, wrap naturally.
- count:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push+pop or on overwrite.
- Counters:
  - Each qualified event increments the counter for its type, including dropped events.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- clear:
  - Highest priority after reset.
  - Zeros pointers, count, overflow and counters.
  - A push or pop in the same cycle is discarded.
- mode_wrap may change at any time; it takes effect on the same cycle's push decision.

Test Plan:
- Reset then 3 events:
  - Stimulus: RAW(1,2) at ts=5, WAR(3,4) at ts=6, WAW(7,0) at ts=7, out_ready=0.
  - Response: count=3, out_data={5,01,1,2}, raw/war/waw_cnt=1/1/1, overflow=0.
  - Then out_ready=1 for 3 cycles yields ts 5, 6, 7 in order, then out_valid=0.
- Stop-on-full:
  - Stimulus: DEPTH=8, mode_wrap=0, 10 RAW events, no pops.
  - Response: count=8, head ts = first event's, overflow=1, raw_cnt=10.
  - 9th/10th events are absent from readout.
- Overwrite mode:
  - Stimulus: mode_wrap=1, 10 events ts 0..9, no pops.
  - Response: count=8, readout yields ts 2..9, overflow=1.
- Simultaneous push+pop:
  - Stimulus: push and pop together while full (both modes).
  - Response: count stays 8, no overflow, FIFO order intact.
  - Also: push with out_ready=1 while empty gives count=1 next cycle.
- Qualification, saturation, clear:
  - Stimulus: hz_type=00, or cap_en=0, with hz_valid=1.
  - Response: no change to count or counters.
  - Stimulus: CNT_W=8, 300 WAW events.
  - Response: waw_cnt=255.
  - Stimulus: clear together with a push.
  - Response: count=0, counters=0, overflow=0, out_valid=0; timestamp keeps running.
- Mid-stream reset:
  - Stimulus: rst_n=0 for 1 cycle with 5 entries held.
  - Response: out_valid=0, count=0, timestamp=0 next cycle.
